pwm_deadtime: RTL and testbench
===============================

# pwm_deadtime

Complementary gate-drive stage that sits directly downstream of the PWM generator and consumes its single-ended PWM output. It splits the PWM into high-side and low-side drive signals and inserts a programmable dead interval, during which both are off, at every transition. It also provides synchronous enable and fault shutdown with a latched fault flag. Its outputs drive the half-bridge pads.

## Interface
- DT_W, default 8: width of the dead-time count.
- reset  in  1  asynchronous, active-high; forces the reset state below.
- clock  in  1  clock; same domain as the PWM generator, rising-edge.
- enable  in  1  1 = drive outputs; 0 = force OFF (not latched).
- pwm_in  in  1  PWM from the upstream generator; synchronous to clock, no synchroniser.
- dead_time  in  DT_W  dead interval setting D; both-off time is D+1 cycles.
- fault  in  1  synchronous active-high fault; forces OFF and sets fault_latched.
- fault_clr  in  1  clears fault_latched when fault is 0.
- out_hi  out  1  high-side drive, registered.
- out_lo  out  1  low-side drive, registered.
- dead_active  out  1  1 while in DEAD_H or DEAD_L.
- fault_latched  out  1  sticky fault flag.
- pulse_drop  out  1  one-cycle strobe when a pulse is swallowed during dead time.

## Operation
- States:
  - OFF: hi=0, lo=0.
  - DEAD_H: 0,0, heading high.
  - HI_ON: 1,0.
  - DEAD_L: 0,0, heading low.
  - LO_ON: 0,1.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Priority, highest first:
  - reset
  - fault or !enable or fault_latched → OFF
  - normal transitions
- OFF → DEAD_H if pwm_in=1, else DEAD_L. Requires enable=1, fault=0 and fault_latched=0.
- LO_ON with pwm_in=1 → DEAD_H. HI_ON with pwm_in=0 → DEAD_L.
- Dead-time counter cnt is DT_W bits.
  - Every entry into DEAD_H or DEAD_L loads cnt with the dead_time value present on that edge.
  - In a DEAD state: cnt==0 → the matching ON state; otherwise cnt decrements.
  - Changes to dead_time take effect only on the next DEAD entry.
- Swallowed pulse:
  - DEAD_H with pwm_in=0 → LO_ON directly; pulse_drop=1 for one cycle.
  - DEAD_L with pwm_in=1 → HI_ON directly; pulse_drop=1 for one cycle.
  - This is safe because the opposite switch was never turned on.
  - The swallow check takes priority over cnt==0.
- Fault latch:
  - fault=1 sets fault_latched on the next edge.
  - fault_clr=1 with fault=0 clears it.
  - If fault and fault_clr are both 1, the latch is set.
- Invariant: out_hi & out_lo is never 1, in any state or on any edge.
- Minimum pulse widths:
  - A pwm_in high pulse shorter than D+2 cycles produces no out_hi.
  - A pwm_in low pulse shorter than D+2 cycles produces no out_lo.

## Timing
- Reset values: state=OFF, cnt=0, out_hi=0, out_lo=0, dead_active=0, fault_latched=0, pulse_drop=0.
- Reset is asynchronous; outputs drop to 0 immediately, including mid-dead-time or mid-pulse.
- Let edge k be the first edge that samples the new pwm_in level.
  - Rising: out_lo=0 from edge k; out_hi=1 from edge k+D+1.
  - Falling: the mirror case.
  - Both-off window: exactly D+1 cycles.
  - D=0 gives a 1-cycle gap; D=2^DT_W−1 gives 2^DT_W cycles, with no wrap.
- Start-up after enable rises (edge e samples enable=1): the selected output turns on at edge e+D+1.
- Shutdown: fault=1 or enable=0 sampled at edge f gives both outputs 0 from edge f, from any state.
- Leaving OFF requires fault_latched=0 at the sampling edge. After fault_clr at edge c, the earliest DEAD entry is edge c+1.
- dead_active=1 exactly on the cycles where state is DEAD_H or DEAD_L.
- pulse_drop is asserted on the edge that makes the swallow transition and cleared on the next edge.

## Test plan
- Nominal, D=3:
  - Stimulus: enable=1; pwm_in period 20 cycles, high 8.
  - Expected: each rising pwm_in gives out_lo fall at k and out_hi rise at k+4; each falling edge mirrors this.
  - Both outputs are never 1 together.
- D=0 and D=255 with DT_W=8:
  - Expected: gaps of 1 and 256 cycles respectively; the counter does not wrap.
- Swallow, D=5:
  - Stimulus: from LO_ON, a 3-cycle pwm_in high pulse.
  - Expected: out_hi stays 0; out_lo returns to 1 on the falling-sample edge; pulse_drop pulses once.
- Fault:
  - Stimulus: fault asserted for 1 cycle while in HI_ON.
  - Expected: out_hi=0 on the same edge and fault_latched=1.
  - Expected: outputs stay 0 with fault_clr=0, and also with fault and fault_clr both 1.
  - Then fault_clr with fault=0: the latch clears and the outputs restart after D+1 cycles.
- Enable and dead_time change:
  - Stimulus: drop enable mid-DEAD_H; outputs 0, fault_latched stays 0; raise enable.
  - Expected: restart after D+1 cycles.
  - Stimulus: change dead_time from 3 to 7 mid-dead.
  - Expected: the current gap stays 4 cycles; the next gap is 8.
- Reset:
  - Stimulus: assert reset asynchronously mid-HI_ON.
  - Expected: all outputs 0 immediately, before the next clock edge.
  - Expected: after release, the first transition waits for enable and applies the full dead interval.

Source files
------------

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage: splits a PWM into high/low-side drives with a
// programmable both-off dead interval, plus enable and latched fault shutdown.
module pwm_deadtime #(
    parameter int unsigned DT_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            out_hi,
    output logic            out_lo,
    output logic            dead_active,
    output logic            fault_latched,
    output logic            pulse_drop
);

    typedef enum logic [2:0] {
        StOff,
        StDeadH,
        StHiOn,
        StDeadL,
        StLoOn
    } state_e;

    state_e          state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            fault_latched_q, fault_latched_d;
    logic            swallow;
    logic            out_hi_q, out_hi_d;
    logic            out_lo_q, out_lo_d;
    logic            dead_active_q, dead_active_d;
    logic            pulse_drop_q, pulse_drop_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StOff;
            cnt_q           <= '0;
            fault_latched_q <= 1'b0;
            out_hi_q        <= 1'b0;
            out_lo_q        <= 1'b0;
            dead_active_q   <= 1'b0;
            pulse_drop_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            fault_latched_q <= fault_latched_d;
            out_hi_q        <= out_hi_d;
            out_lo_q        <= out_lo_d;
            dead_active_q   <= dead_active_d;
            pulse_drop_q    <= pulse_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        swallow = 1'b0;

        // Set wins over clear when both are asserted.
        if (fault) begin
            fault_latched_d = 1'b1;
        end else if (fault_clr) begin
            fault_latched_d = 1'b0;
        end else begin
            fault_latched_d = fault_latched_q;
        end

        if (fault || !enable || fault_latched_q) begin
            state_d = StOff;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = pwm_in ? StDeadH : StDeadL;
                    cnt_d   = dead_time;
                end
                StLoOn: begin
                    if (pwm_in) begin
                        state_d = StDeadH;
                        cnt_d   = dead_time;
                    end
                end
                StHiOn: begin
                    if (!pwm_in) begin
                        state_d = StDeadL;
                        cnt_d   = dead_time;
                    end
                end
                StDeadH: begin
                    // Low side is still off, so returning to it directly is safe.
                    if (!pwm_in) begin
                        state_d = StLoOn;
                        swallow = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = StHiOn;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                StDeadL: begin
                    if (pwm_in) begin
                        state_d = StHiOn;
                        swallow = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = StLoOn;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_comb begin
        out_hi_d      = (state_d == StHiOn);
        out_lo_d      = (state_d == StLoOn);
        dead_active_d = (state_d == StDeadH) || (state_d == StDeadL);
        pulse_drop_d  = swallow;
    end

    assign out_hi        = out_hi_q;
    assign out_lo        = out_lo_q;
    assign dead_active   = dead_active_q;
    assign fault_latched = fault_latched_q;
    assign pulse_drop    = pulse_drop_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: dead intervals, pulse swallowing, fault,
// enable, dead_time changes and asynchronous reset, with hand-derived expectations.
module tb_pwm_deadtime;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       pwm_in;
    logic [7:0] dead_time;
    logic       fault;
    logic       fault_clr;
    logic       out_hi;
    logic       out_lo;
    logic       dead_active;
    logic       fault_latched;
    logic       pulse_drop;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pwm_deadtime #(
        .DT_W(8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .pwm_in       (pwm_in),
        .dead_time    (dead_time),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .out_hi       (out_hi),
        .out_lo       (out_lo),
        .dead_active  (dead_active),
        .fault_latched(fault_latched),
        .pulse_drop   (pulse_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic hi, input logic lo,
                              input logic dead, input logic drop, input logic flt);
        check({tag, ".out_hi"}, {31'd0, out_hi}, {31'd0, hi});
        check({tag, ".out_lo"}, {31'd0, out_lo}, {31'd0, lo});
        check({tag, ".dead_active"}, {31'd0, dead_active}, {31'd0, dead});
        check({tag, ".pulse_drop"}, {31'd0, pulse_drop}, {31'd0, drop});
        check({tag, ".fault_latched"}, {31'd0, fault_latched}, {31'd0, flt});
    endtask

    // One active edge, then settle 1 time unit past it before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a level for `hold` cycles: D+1 dead cycles, then the matching output on.
    task automatic pulse(input string tag, input logic level, input int d, input int hold);
        pwm_in = level;
        for (int i = 0; i <= d; i++) begin
            tick();
            expect_out({tag, ".dead"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        expect_out({tag, ".on"}, level, ~level, 1'b0, 1'b0, 1'b0);
        for (int i = d + 2; i < hold; i++) begin
            tick();
            expect_out({tag, ".hold"}, level, ~level, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Shoot-through guard, sampled away from the active edge.
    always @(negedge clock) begin
        check("no_overlap", {31'd0, out_hi & out_lo}, 32'd0);
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        pwm_in    = 1'b0;
        dead_time = 8'd3;
        fault     = 1'b0;
        fault_clr = 1'b0;
        tick();
        tick();
        expect_out("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("idle_disabled", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Nominal D=3: start-up low side, then two 20-cycle periods with 8 high.
        enable = 1'b1;
        pulse("startup_lo", 1'b0, 3, 6);
        pulse("nom_hi0", 1'b1, 3, 8);
        pulse("nom_lo0", 1'b0, 3, 12);
        pulse("nom_hi1", 1'b1, 3, 8);
        pulse("nom_lo1", 1'b0, 3, 12);

        // Extremes of the dead interval: 1-cycle and 256-cycle gaps.
        dead_time = 8'd0;
        pulse("d0_hi", 1'b1, 0, 4);
        pulse("d0_lo", 1'b0, 0, 4);
        dead_time = 8'd255;
        pulse("d255_hi", 1'b1, 255, 258);
        pulse("d255_lo", 1'b0, 255, 258);

        // Swallowed high pulse from LO_ON, D=5, 3 cycles wide.
        dead_time = 8'd5;
        pwm_in    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("swallow_h.dead", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        pwm_in = 1'b0;
        tick();
        expect_out("swallow_h.drop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("swallow_h.after", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Swallowed low pulse from HI_ON.
        pulse("pre_swl", 1'b1, 5, 8);
        pwm_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("swallow_l.dead", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        pwm_in = 1'b1;
        tick();
        expect_out("swallow_l.drop", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("swallow_l.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // One-cycle fault while in HI_ON.
        dead_time = 8'd3;
        fault     = 1'b1;
        tick();
        expect_out("fault.hit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        fault = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("fault.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        fault     = 1'b1;
        fault_clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("fault.both", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        fault = 1'b0;
        tick();
        expect_out("fault.clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        fault_clr = 1'b0;
        pulse("fault.restart", 1'b1, 3, 6);

        // Enable dropped mid-DEAD_H, then restored.
        pulse("en_pre", 1'b0, 3, 6);
        pwm_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("en.dead", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("en.off", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        enable = 1'b1;
        pulse("en.restart", 1'b1, 3, 6);

        // dead_time changed mid-dead: current gap stays 4, next gap is 8.
        pwm_in = 1'b0;
        tick();
        expect_out("dtchg.dead", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        dead_time = 8'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("dtchg.dead", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        expect_out("dtchg.lo_on", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("dtchg.lo_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse("dtchg.next", 1'b1, 7, 10);

        // Asynchronous reset mid-HI_ON, checked between clock edges.
        #2;
        reset = 1'b1;
        #1;
        expect_out("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("post_reset.wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        enable = 1'b1;
        pulse("post_reset.start", 1'b1, 7, 9);

        @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
